// File: rtl/pipe_field_gen.sv
// pipe_field_gen: produces the three scrolling pipe descriptors and the score
// for the display. It moves the pipes left once per frame and recycles each
// pipe to the right with a pseudo-random gap center once it leaves the screen.
module pipe_field_gen #(
  parameter int         SCREEN_W    = 640,
  parameter int         PIPE_W      = 60,
  parameter int         SPACING     = 240,
  parameter int         BIRD_X      = 200,
  parameter int         CENTER_MIN  = 120,
  parameter int         INIT_CENTER = 240,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [2:0]  state,
  input  logic [1:0]  level,
  output logic [10:0] pipe_center_0,
  output logic [10:0] pipe_center_1,
  output logic [10:0] pipe_center_2,
  output logic [10:0] pipe_pisiton_0,
  output logic [10:0] pipe_pisiton_1,
  output logic [10:0] pipe_pisiton_2,
  output logic [10:0] pipe_distance_0,
  output logic [10:0] pipe_distance_1,
  output logic [10:0] pipe_distance_2,
  output logic [7:0]  score,
  output logic        pass_pulse
);

  localparam int DATA_W     = 11;
  localparam int CENTER_MAX = 360;
  localparam logic [DATA_W-1:0] PITCH3 = DATA_W'(3 * SPACING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } mode_t;

  mode_t             mode;
  logic [7:0]        lfsr;
  logic              lfsr_fb;
  logic [DATA_W-1:0] pos [3];
  logic [DATA_W-1:0] cen [3];
  logic [DATA_W-1:0] dst [3];
  logic [7:0]        score_q;
  logic              pulse_q;

  logic [DATA_W-1:0] spd;
  logic [DATA_W-1:0] next_pos [3];
  logic [2:0]        wrap;
  logic              any_pass;

  // Scroll speed in pixels per frame: 2, 4, 6, 8.
  function automatic logic [DATA_W-1:0] speed_of(input logic [1:0] lv);
    return DATA_W'({lv, 1'b0}) + DATA_W'(2);
  endfunction

  // Gap half-height per level: narrower gaps at higher difficulty.
  function automatic logic [DATA_W-1:0] dist_of(input logic [1:0] lv);
    case (lv)
      2'd0:    return DATA_W'(100);
      2'd1:    return DATA_W'(85);
      2'd2:    return DATA_W'(70);
      default: return DATA_W'(55);
    endcase
  endfunction

  // Fresh gap center; falls back to the 7-bit LFSR slice when the full byte
  // would push the gap too low on screen.
  function automatic logic [DATA_W-1:0] new_center(input logic [7:0] l);
    logic [DATA_W-1:0] wide;
    wide = DATA_W'(CENTER_MIN) + DATA_W'(l);
    if (wide <= DATA_W'(CENTER_MAX))
      return wide;
    else
      return DATA_W'(CENTER_MIN) + DATA_W'(l[6:0]);
  endfunction

  // Score saturates at 255 instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Per-pipe next position, wrap decision and bird-pass detection for this tick.
  always_comb begin
    spd      = speed_of(level);
    any_pass = 1'b0;
    wrap     = '0;
    next_pos = '{default: '0};
    for (int i = 0; i < 3; i++) begin
      wrap[i]     = pos[i] < spd;
      next_pos[i] = wrap[i] ? (pos[i] + PITCH3 - spd) : (pos[i] - spd);
      if (!wrap[i] &&
          (pos[i] + DATA_W'(PIPE_W) >= DATA_W'(BIRD_X)) &&
          (next_pos[i] + DATA_W'(PIPE_W) < DATA_W'(BIRD_X)))
        any_pass = 1'b1;
    end
  end

  // Free-running gap-center LFSR; the tap set keeps it out of the zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[6:0], lfsr_fb};
  end

  // Game-mode FSM plus the pipe field and score registers it governs.
  // Reset loads the level-0 distance as a constant; IDLE then tracks the
  // live level from the first clock onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= IDLE;
      for (int i = 0; i < 3; i++) begin
        pos[i] <= DATA_W'(SCREEN_W + i * SPACING);
        cen[i] <= DATA_W'(INIT_CENTER);
        dst[i] <= dist_of(2'd0);
      end
      score_q <= 8'd0;
      pulse_q <= 1'b0;
    end else begin
      case (mode)
        IDLE:    if (state == 3'd1) mode <= RUN;
        RUN:     if (state == 3'd0) mode <= IDLE;
                 else if (state == 3'd2 || state == 3'd3) mode <= FROZEN;
        FROZEN:  if (state == 3'd0) mode <= IDLE;
                 else if (state == 3'd1) mode <= RUN;
        default: mode <= IDLE;
      endcase

      if (mode == IDLE || state == 3'd0) begin
        for (int i = 0; i < 3; i++) begin
          pos[i] <= DATA_W'(SCREEN_W + i * SPACING);
          cen[i] <= DATA_W'(INIT_CENTER);
          dst[i] <= dist_of(level);
        end
        score_q <= 8'd0;
        pulse_q <= 1'b0;
      end else if (mode == RUN && frame_tick) begin
        for (int i = 0; i < 3; i++) begin
          pos[i] <= next_pos[i];
          if (wrap[i]) begin
            cen[i] <= new_center(lfsr);
            dst[i] <= dist_of(level);
          end
        end
        if (any_pass)
          score_q <= sat_inc(score_q);
        pulse_q <= any_pass;
      end else begin
        pulse_q <= 1'b0;
      end
    end
  end

  assign pipe_pisiton_0  = pos[0];
  assign pipe_pisiton_1  = pos[1];
  assign pipe_pisiton_2  = pos[2];
  assign pipe_center_0   = cen[0];
  assign pipe_center_1   = cen[1];
  assign pipe_center_2   = cen[2];
  assign pipe_distance_0 = dst[0];
  assign pipe_distance_1 = dst[1];
  assign pipe_distance_2 = dst[2];
  assign score           = score_q;
  assign pass_pulse      = pulse_q;

endmodule

// File: tb/tb_pipe_field_gen.sv
// tb_pipe_field_gen: directed table, saturation and reset sequences, plus a
// randomized run compared every cycle against a behavioural model.
module tb_pipe_field_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic [2:0]  state = 3'd0;
  logic [1:0]  level = 2'd1;
  logic [10:0] pipe_center_0, pipe_center_1, pipe_center_2;
  logic [10:0] pipe_pisiton_0, pipe_pisiton_1, pipe_pisiton_2;
  logic [10:0] pipe_distance_0, pipe_distance_1, pipe_distance_2;
  logic [7:0]  score;
  logic        pass_pulse;

  pipe_field_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_tick      (frame_tick),
    .state           (state),
    .level           (level),
    .pipe_center_0   (pipe_center_0),
    .pipe_center_1   (pipe_center_1),
    .pipe_center_2   (pipe_center_2),
    .pipe_pisiton_0  (pipe_pisiton_0),
    .pipe_pisiton_1  (pipe_pisiton_1),
    .pipe_pisiton_2  (pipe_pisiton_2),
    .pipe_distance_0 (pipe_distance_0),
    .pipe_distance_1 (pipe_distance_1),
    .pipe_distance_2 (pipe_distance_2),
    .score           (score),
    .pass_pulse      (pass_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [10:0] d_pos [3];
  logic [10:0] d_cen [3];
  logic [10:0] d_dst [3];
  assign d_pos[0] = pipe_pisiton_0;
  assign d_pos[1] = pipe_pisiton_1;
  assign d_pos[2] = pipe_pisiton_2;
  assign d_cen[0] = pipe_center_0;
  assign d_cen[1] = pipe_center_1;
  assign d_cen[2] = pipe_center_2;
  assign d_dst[0] = pipe_distance_0;
  assign d_dst[1] = pipe_distance_1;
  assign d_dst[2] = pipe_distance_2;

  // ---------------- behavioural reference model ----------------
  int m_mode;  // 0 idle, 1 running, 2 frozen
  int m_pos [3];
  int m_cen [3];
  int m_dst [3];
  int m_score;
  int m_pulse;
  int m_lfsr;
  bit mchk = 1'b0;

  function automatic int m_dist(input int lv);
    return 100 - 15 * lv;
  endfunction

  task automatic m_init(input int dist_val);
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = 640 + 240 * i;
      m_cen[i] = 240;
      m_dst[i] = dist_val;
    end
    m_score = 0;
    m_pulse = 0;
  endtask

  task automatic m_step(input int st, input int lv, input bit tk);
    int sp, p, c, nmode;
    bit passed;
    nmode = m_mode;
    if (m_mode == 0 && st == 1) nmode = 1;
    else if (m_mode == 1 && st == 0) nmode = 0;
    else if (m_mode == 1 && (st == 2 || st == 3)) nmode = 2;
    else if (m_mode == 2 && st == 0) nmode = 0;
    else if (m_mode == 2 && st == 1) nmode = 1;

    if (m_mode == 0 || st == 0) begin
      m_init(m_dist(lv));
    end else if (m_mode == 1 && tk) begin
      sp = 2 + 2 * lv;
      passed = 1'b0;
      for (int i = 0; i < 3; i++) begin
        p = m_pos[i];
        if (p < sp) begin
          m_pos[i] = p + 720 - sp;
          c = 120 + m_lfsr;
          if (c > 360) c = 120 + (m_lfsr % 128);
          m_cen[i] = c;
          m_dst[i] = m_dist(lv);
        end else begin
          if (p + 60 >= 200 && p - sp + 60 < 200) passed = 1'b1;
          m_pos[i] = p - sp;
        end
      end
      if (passed && m_score < 255) m_score = m_score + 1;
      m_pulse = passed ? 1 : 0;
    end else begin
      m_pulse = 0;
    end
    m_mode = nmode;
    m_lfsr = ((m_lfsr << 1) & 8'hFE) | int'(^(m_lfsr[7:0] & 8'hB8));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_lfsr = 8'hA5;
      m_init(100);
    end else begin
      m_step(int'(state), int'(level), frame_tick);
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model pos%0d", i), int'(d_pos[i]), m_pos[i]);
        check($sformatf("model cen%0d", i), int'(d_cen[i]), m_cen[i]);
        check($sformatf("model dst%0d", i), int'(d_dst[i]), m_dst[i]);
      end
      check("model score", int'(score), m_score);
      check("model pass_pulse", int'(pass_pulse), m_pulse);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0] st;
    logic [1:0] lv;
    logic       tk;
    int         n;
    int         pos0;
    int         pos1;
    int         scr;
    int         pls;
    int         dst0;
    bit         cen_rng;
  } vec_t;

  vec_t tbl [17];

  task automatic step(input logic [2:0] st, input logic [1:0] lv, input logic tk);
    state = st;
    level = lv;
    frame_tick = tk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit saw_pulse;

    tbl[0]  = '{3'd0, 2'd1, 1'b0, 1,  640, 880, 0, 0, 85,  1'b0};
    tbl[1]  = '{3'd1, 2'd0, 1'b0, 1,  640, 880, 0, 0, 100, 1'b0};
    tbl[2]  = '{3'd1, 2'd0, 1'b1, 1,  638, 878, 0, 0, 100, 1'b0};
    tbl[3]  = '{3'd1, 2'd0, 1'b0, 1,  638, 878, 0, 0, 100, 1'b0};
    tbl[4]  = '{3'd0, 2'd0, 1'b0, 1,  640, 880, 0, 0, 100, 1'b0};
    tbl[5]  = '{3'd1, 2'd3, 1'b0, 1,  640, 880, 0, 0, 55,  1'b0};
    tbl[6]  = '{3'd1, 2'd3, 1'b1, 62, 144, 384, 0, 0, 55,  1'b0};
    tbl[7]  = '{3'd1, 2'd3, 1'b1, 1,  136, 376, 1, 1, 55,  1'b0};
    tbl[8]  = '{3'd1, 2'd3, 1'b0, 1,  136, 376, 1, 0, 55,  1'b0};
    tbl[9]  = '{3'd1, 2'd3, 1'b1, 17, 0,   240, 1, 0, 55,  1'b0};
    tbl[10] = '{3'd1, 2'd3, 1'b1, 1,  712, 232, 1, 0, 55,  1'b1};
    tbl[11] = '{3'd2, 2'd3, 1'b0, 1,  712, 232, 1, 0, 55,  1'b0};
    tbl[12] = '{3'd2, 2'd3, 1'b1, 10, 712, 232, 1, 0, 55,  1'b0};
    tbl[13] = '{3'd1, 2'd3, 1'b0, 1,  712, 232, 1, 0, 55,  1'b0};
    tbl[14] = '{3'd1, 2'd3, 1'b1, 1,  704, 224, 1, 0, 55,  1'b0};
    tbl[15] = '{3'd0, 2'd3, 1'b1, 1,  640, 880, 0, 0, 55,  1'b0};
    tbl[16] = '{3'd4, 2'd3, 1'b1, 1,  640, 880, 0, 0, 55,  1'b0};

    // Power-on reset, checked while rst_n is still low.
    #1 rst_n = 1'b0;
    #1;
    check("reset pos0", int'(pipe_pisiton_0), 640);
    check("reset pos1", int'(pipe_pisiton_1), 880);
    check("reset pos2", int'(pipe_pisiton_2), 1120);
    check("reset cen0", int'(pipe_center_0), 240);
    check("reset score", int'(score), 0);
    check("reset pulse", int'(pass_pulse), 0);
    #1 rst_n = 1'b1;
    mchk = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 17; v++) begin
      for (int k = 0; k < tbl[v].n; k++)
        step(tbl[v].st, tbl[v].lv, tbl[v].tk);
      check($sformatf("vec%0d pos0", v), int'(pipe_pisiton_0), tbl[v].pos0);
      check($sformatf("vec%0d pos1", v), int'(pipe_pisiton_1), tbl[v].pos1);
      check($sformatf("vec%0d score", v), int'(score), tbl[v].scr);
      check($sformatf("vec%0d pulse", v), int'(pass_pulse), tbl[v].pls);
      check($sformatf("vec%0d dist0", v), int'(pipe_distance_0), tbl[v].dst0);
      if (tbl[v].cen_rng)
        check($sformatf("vec%0d cen0 in 120..360", v),
              int'(pipe_center_0 >= 11'd120 && pipe_center_0 <= 11'd360), 1);
    end

    // Randomized play: mostly running, with pauses, restarts, odd codes and level changes.
    begin
      logic [1:0] lv;
      logic [2:0] st;
      int r;
      lv = 2'($urandom_range(0, 3));
      for (int c = 0; c < 3000; c++) begin
        r = $urandom_range(0, 99);
        if (r < 2)       st = 3'd0;
        else if (r < 7)  st = 3'd2;
        else if (r < 9)  st = 3'd3;
        else if (r < 11) st = 3'(4 + $urandom_range(0, 3));
        else             st = 3'd1;
        if ($urandom_range(0, 99) < 2) lv = 2'($urandom_range(0, 3));
        step(st, lv, 1'($urandom_range(0, 1)));
      end
    end

    // Score saturation: a pass every 30 ticks at level 3.
    step(3'd0, 2'd3, 1'b0);
    step(3'd1, 2'd3, 1'b0);
    for (int c = 0; c < 9000; c++)
      step(3'd1, 2'd3, 1'b1);
    check("sat score", int'(score), 255);
    saw_pulse = 1'b0;
    for (int c = 0; c < 40 && !saw_pulse; c++) begin
      step(3'd1, 2'd3, 1'b1);
      if (pass_pulse) saw_pulse = 1'b1;
    end
    check("sat pulse seen", int'(saw_pulse), 1);
    check("sat score held", int'(score), 255);

    // Asynchronous reset between clock edges.
    step(3'd1, 2'd3, 1'b1);
    #2;
    level = 2'd0;
    rst_n = 1'b0;
    #1;
    check("midreset pos0", int'(pipe_pisiton_0), 640);
    check("midreset pos1", int'(pipe_pisiton_1), 880);
    check("midreset pos2", int'(pipe_pisiton_2), 1120);
    check("midreset cen0", int'(pipe_center_0), 240);
    check("midreset dist0", int'(pipe_distance_0), 100);
    check("midreset score", int'(score), 0);
    check("midreset pulse", int'(pass_pulse), 0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++)
      step(3'd1, 2'd0, 1'b1);

    mchk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
